// File: rtl/aes_sbox_stream_cipher.sv
// aes_sbox_stream_cipher: byte-serial stream cipher, out = in ^ SBOX[key ^ idx].
// The same block encrypts and decrypts; one byte per clock, two register stages.
// Optional build macro STREAM_CIPHER_IDLE_RESTART_EN: every idle cycle reloads
// the keystream index so each burst starts a fresh keystream.
module aes_sbox_stream_cipher #(
  parameter logic [7:0] INDEX_INIT = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,          // active-high despite the name
  input  logic       din_valid,
  input  logic [7:0] simmetric_key,
  input  logic [7:0] txt_in_char,
  output logic [7:0] txt_out_char,
  output logic       dout_ready
);

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  logic [7:0] idx_q, idx_d;
  logic [7:0] char_q, char_d;
  logic [7:0] addr_q, addr_d;
  logic       v1_q, v1_d;
  logic [7:0] out_q, out_d;
  logic       ready_q, ready_d;

  // Stage 1: capture the byte and its S-box address, advance the keystream index.
  always_comb begin
    idx_d  = idx_q;
    char_d = char_q;
    addr_d = addr_q;
    v1_d   = 1'b0;
    if (din_valid) begin
      char_d = txt_in_char;
      addr_d = simmetric_key ^ idx_q;
      v1_d   = 1'b1;
      idx_d  = idx_q + 8'd1;
    end
`ifdef STREAM_CIPHER_IDLE_RESTART_EN
    else begin
      idx_d = INDEX_INIT;
    end
`endif
  end

  // Stage 2: apply the keystream byte; the result holds while no new byte arrives.
  always_comb begin
    out_d   = v1_q ? (char_q ^ SBOX[addr_q]) : out_q;
    ready_d = v1_q;
  end

  // Pipeline and index registers; reset drops anything in flight.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      idx_q   <= INDEX_INIT;
      char_q  <= 8'h00;
      addr_q  <= 8'h00;
      v1_q    <= 1'b0;
      out_q   <= 8'h00;
      ready_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      char_q  <= char_d;
      addr_q  <= addr_d;
      v1_q    <= v1_d;
      out_q   <= out_d;
      ready_q <= ready_d;
    end
  end

  assign txt_out_char = out_q;
  assign dout_ready   = ready_q;

endmodule

// File: tb/tb_aes_sbox_stream_cipher.sv
// Scoreboard bench for aes_sbox_stream_cipher; S-box reference derived from GF(2^8).
module tb_aes_sbox_stream_cipher;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       din_valid = 1'b0;
  logic [7:0] simmetric_key = 8'h00;
  logic [7:0] txt_in_char = 8'h00;
  logic [7:0] txt_out_char;
  logic       dout_ready;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] cap_q[$];
  logic       capture_en = 1'b0;
  logic [7:0] midx = 8'h00;
  logic [7:0] sbox_ref [0:255];
  logic [7:0] plain [0:299];

  aes_sbox_stream_cipher #(.INDEX_INIT(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .simmetric_key(simmetric_key),
    .txt_in_char(txt_in_char), .txt_out_char(txt_out_char), .dout_ready(dout_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] v);
    logic [7:0] inv, s;
    inv = 8'h00;
    for (int j = 1; j < 256; j++)
      if (gmul(v, 8'(j)) == 8'h01) inv = 8'(j);
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every presented result must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst_n && dout_ready) begin
      if (capture_en) cap_q.push_back(txt_out_char);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h expected no output", txt_out_char);
      end else begin
        chk("out_byte", txt_out_char, exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [7:0] k, input logic [7:0] d, input logic [7:0] e);
    @(negedge clk);
    din_valid = 1'b1;
    simmetric_key = k;
    txt_in_char = d;
    exp_q.push_back(e);
    midx = midx + 8'd1;
  endtask

  task automatic send_model(input logic [7:0] k, input logic [7:0] d);
    send(k, d, d ^ sbox_ref[k ^ midx]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      din_valid = 1'b0;
      txt_in_char = 8'($urandom);
`ifdef STREAM_CIPHER_IDLE_RESTART_EN
      midx = 8'h00;
`endif
    end
  endtask

  task automatic drain(input string name);
    idle(4);
    #2;
    chk(name, 8'(exp_q.size()), 8'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    din_valid = 1'b0;
    #1;
    chk("ready_async_drop", {7'd0, dout_ready}, 8'h00);
    chk("out_reset", txt_out_char, 8'h00);
    exp_q.delete();
    midx = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) sbox_ref[i] = sbox_calc(8'(i));
    #12;
    chk("reset_ready", {7'd0, dout_ready}, 8'h00);
    chk("reset_out", txt_out_char, 8'h00);
    @(negedge clk);
    rst_n = 1'b0;

    // single byte
    send(8'h12, 8'h41, 8'h88);
    drain("t1_drain");

    // back-to-back
    do_reset();
    send(8'h12, 8'h41, 8'h88);
    send(8'h12, 8'h42, 8'h3f);
    drain("t2_drain");

    // gap between bytes
    do_reset();
    send(8'h12, 8'h41, 8'h88);
    idle(3);
`ifdef STREAM_CIPHER_IDLE_RESTART_EN
    send(8'h12, 8'h42, 8'h8b);
`else
    send(8'h12, 8'h42, 8'h3f);
`endif
    drain("t5_drain");

    // index wrap with key 00
    do_reset();
    send(8'h00, 8'h00, 8'h63);
    for (int i = 0; i < 255; i++) send_model(8'($urandom), 8'($urandom));
    send(8'h00, 8'h00, 8'h63);
    drain("t4_drain");

    // round trip, 300 bytes back-to-back
    do_reset();
    cap_q.delete();
    capture_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      plain[i] = 8'($urandom);
      send_model(8'h12, plain[i]);
    end
    drain("enc_drain");
    capture_en = 1'b0;
    chk("cipher_len_lo", 8'(cap_q.size()), 8'(300));
    do_reset();
    for (int i = 0; i < 300 && cap_q.size() > 0; i++) send(8'h12, cap_q.pop_front(), plain[i]);
    drain("dec_drain");

    // random keys with random gaps
    do_reset();
    for (int i = 0; i < 200; i++) begin
      send_model(8'($urandom), 8'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    drain("rand_drain");

    // reset with two bytes in flight
    do_reset();
    send(8'h12, 8'h41, 8'h00);
    send(8'h12, 8'h42, 8'h00);
    do_reset();
    send(8'h12, 8'h41, 8'h88);
    drain("t6_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
